gray_seq_counter: RTL and testbench



---
 rtl/gray_seq_counter_if.sv | 24 ++
 rtl/gray_seq_counter.sv | 75 +++++++
 tb/tb_gray_seq_counter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_seq_counter_if.sv
// Control and result signals of gray_seq_counter, grouped so the counter and
// its driver share one bundle; clk and rst stay outside as plain ports.
interface gray_seq_counter_if #(
    parameter int SIZE = 4
);
    logic            en;
    logic            up_dn;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic [SIZE-1:0] bin_cnt;
    logic [SIZE-1:0] gray_out;
    logic            tc;

    // Master drives the controls and observes the counter outputs.
    modport master (
        output en, up_dn, load, load_val,
        input  bin_cnt, gray_out, tc
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bin_cnt, gray_out, tc
    );
endinterface

// File: rtl/gray_seq_counter.sv
// Up/down binary counter with load, wrap/saturate ends and a terminal-count
// pulse; the Gray output is registered from the same next value as the count.
module gray_seq_counter #(
    parameter int SIZE = 4,
    parameter int WRAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    gray_seq_counter_if.slave  s_if
);
    localparam logic [SIZE-1:0] MAX_VAL = '1;
    localparam logic [SIZE-1:0] MIN_VAL = '0;
    localparam logic [SIZE-1:0] ONE     = SIZE'(1);

    logic [SIZE-1:0] r_bin;
    logic [SIZE-1:0] r_gray;
    logic            r_tc;

    logic [SIZE-1:0] w_bin_next;
    logic [SIZE-1:0] w_gray_next;
    logic            w_tc_next;
    logic            w_at_max;
    logic            w_at_min;

    function automatic logic [SIZE-1:0] bin_to_gray(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_at_max = (r_bin == MAX_VAL);
    assign w_at_min = (r_bin == MIN_VAL);

    // Priority: load, then enabled step, then hold; tc is a one-edge pulse.
    always_comb begin
        w_bin_next = r_bin;
        w_tc_next  = 1'b0;
        if (s_if.load) begin
            w_bin_next = s_if.load_val;
        end else if (s_if.en) begin
            if (s_if.up_dn) begin
                if (w_at_max) begin
                    w_tc_next  = 1'b1;
                    w_bin_next = (WRAP != 0) ? MIN_VAL : MAX_VAL;
                end else begin
                    w_bin_next = r_bin + ONE;
                end
            end else begin
                if (w_at_min) begin
                    w_tc_next  = 1'b1;
                    w_bin_next = (WRAP != 0) ? MAX_VAL : MIN_VAL;
                end else begin
                    w_bin_next = r_bin - ONE;
                end
            end
        end
    end

    // Encoding the next value keeps gray_out glitch-free and in step with bin_cnt.
    assign w_gray_next = bin_to_gray(w_bin_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_tc   <= w_tc_next;
        end
    end

    assign s_if.bin_cnt  = r_bin;
    assign s_if.gray_out = r_gray;
    assign s_if.tc       = r_tc;
endmodule

// File: tb/tb_gray_seq_counter.sv
// Bench for gray_seq_counter: a wrapping and a saturating instance share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_gray_seq_counter;
    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            r_en = 1'b0;
    logic            r_up = 1'b0;
    logic            r_ld = 1'b0;
    logic [SIZE-1:0] r_lv = '0;

    gray_seq_counter_if #(.SIZE(SIZE)) a_if ();
    gray_seq_counter_if #(.SIZE(SIZE)) b_if ();

    assign a_if.en = r_en;
    assign a_if.up_dn = r_up;
    assign a_if.load = r_ld;
    assign a_if.load_val = r_lv;
    assign b_if.en = r_en;
    assign b_if.up_dn = r_up;
    assign b_if.load = r_ld;
    assign b_if.load_val = r_lv;

    gray_seq_counter #(.SIZE(SIZE), .WRAP(1)) u_wrap (.clk(clk), .rst(rst), .s_if(a_if.slave));
    gray_seq_counter #(.SIZE(SIZE), .WRAP(0)) u_sat  (.clk(clk), .rst(rst), .s_if(b_if.slave));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model state per instance: 0 = wrapping, 1 = saturating.
    int            m_cnt   [2] = '{0, 0};
    bit            m_tc    [2] = '{1'b0, 1'b0};
    int            m_flips [2] = '{-1, -1};
    logic [SIZE-1:0] prev_gray [2] = '{'0, '0};

    function automatic logic [SIZE-1:0] gray_of(input int v);
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] g;
        b = v[SIZE-1:0];
        for (int i = 0; i < SIZE - 1; i++) g[i] = b[i] ^ b[i+1];
        g[SIZE-1] = b[SIZE-1];
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] dut_bin(input int k);
        return (k == 0) ? a_if.bin_cnt : b_if.bin_cnt;
    endfunction
    function automatic logic [SIZE-1:0] dut_gray(input int k);
        return (k == 0) ? a_if.gray_out : b_if.gray_out;
    endfunction
    function automatic logic dut_tc(input int k);
        return (k == 0) ? a_if.tc : b_if.tc;
    endfunction

    // ---------------- behavioural model ----------------
    localparam int TOP = (1 << SIZE) - 1;
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (r_ld) begin
                    m_cnt[k] = int'(r_lv);
                    m_tc[k] = 1'b0;
                    m_flips[k] = -1;
                end else if (r_en) begin
                    if (r_up && m_cnt[k] == TOP) begin
                        m_tc[k] = 1'b1;
                        m_cnt[k] = (k == 0) ? 0 : TOP;
                        m_flips[k] = (k == 0) ? 1 : 0;
                    end else if (!r_up && m_cnt[k] == 0) begin
                        m_tc[k] = 1'b1;
                        m_cnt[k] = (k == 0) ? TOP : 0;
                        m_flips[k] = (k == 0) ? 1 : 0;
                    end else begin
                        m_tc[k] = 1'b0;
                        m_cnt[k] = r_up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                        m_flips[k] = 1;
                    end
                end else begin
                    m_tc[k] = 1'b0;
                    m_flips[k] = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("bin_cnt[%0d]", k), 32'(dut_bin(k)), 32'(m_cnt[k]));
                check($sformatf("gray_out[%0d]", k), 32'(dut_gray(k)), 32'(gray_of(m_cnt[k])));
                check($sformatf("tc[%0d]", k), 32'(dut_tc(k)), 32'(m_tc[k]));
                if (m_flips[k] >= 0)
                    check($sformatf("gray_flips[%0d]", k),
                          32'($countones(dut_gray(k) ^ prev_gray[k])), 32'(m_flips[k]));
                prev_gray[k] = dut_gray(k);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic ld, input logic [SIZE-1:0] lv, input logic e, input logic ud);
        r_ld = ld;
        r_lv = lv;
        r_en = e;
        r_up = ud;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input int k, input string tag, input int bin,
                       input logic [SIZE-1:0] gray, input logic tc);
        check({tag, "_bin"}, 32'(dut_bin(k)), 32'(bin));
        check({tag, "_gray"}, 32'(dut_gray(k)), 32'(gray));
        check({tag, "_tc"}, 32'(dut_tc(k)), 32'(tc));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_tc[k] = 1'b0;
            m_flips[k] = -1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2;
        lit(0, "rst_a", 0, 4'b0000, 1'b0);
        lit(1, "rst_b", 0, 4'b0000, 1'b0);
        r_en = 1'b1;
        r_up = 1'b1;
        @(posedge clk);
        #1;
        lit(0, "rst_hold", 0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;

        repeat (9) step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "up9", 9, 4'b1101, 1'b0);

        // Asynchronous reset between edges, seen before the next edge.
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        lit(0, "mid_rst_a", 0, 4'b0000, 1'b0);
        lit(1, "mid_rst_b", 0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "after_rst", 1, 4'b0001, 1'b0);

        // Full up sweep with wrap / saturate at the top.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        repeat (15) step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "sweep15", 15, 4'b1000, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "wrap_top", 0, 4'b0000, 1'b1);
        lit(1, "sat_top", 15, 4'b1000, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "wrap_next", 1, 4'b0001, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        lit(1, "sat_drop_en", 15, 4'b1000, 1'b0);

        // Down wrap from zero.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        lit(0, "down_wrap", 15, 4'b1000, 1'b1);
        lit(1, "down_sat", 0, 4'b0000, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        lit(0, "down_next", 14, 4'b1001, 1'b0);

        // Load beats enable on the same edge.
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd12, 1'b1, 1'b1);
        lit(0, "load_prio", 12, 4'b1010, 1'b0);

        // Saturate with enable held high.
        step(1'b1, 4'd14, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(1, "sat1", 15, 4'b1000, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(1, "sat2", 15, 4'b1000, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(1, "sat3", 15, 4'b1000, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        lit(1, "sat_off", 15, 4'b1000, 1'b0);

        // Direction flip takes effect on the same edge.
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        lit(0, "flip_up", 4, 4'b0110, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        lit(0, "flip_dn", 3, 4'b0010, 1'b0);

        // Hold ignores load_val and direction; then count down to the floor.
        step(1'b0, 4'hA, 1'b0, 1'b1);
        lit(1, "hold", 3, 4'b0010, 1'b0);
        repeat (4) step(1'b0, 4'd0, 1'b1, 1'b0);
        lit(0, "down_floor_a", 15, 4'b1000, 1'b1);
        lit(1, "down_floor_b", 0, 4'b0000, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        lit(1, "floor_again", 0, 4'b0000, 1'b1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
